// File: rtl/lcd_pkg.sv
// Shared constants, mode encoding and DDRAM address helpers for the LCD bus decoder.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;  // 8'h03 is also home
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;  // bit7 mask, low 7 bits = address
    localparam logic [7:0] CMD_FUNC_4BIT = 8'h20;
    localparam logic [7:0] CMD_FUNC_8BIT = 8'h30;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;
    localparam logic [6:0] FRAME_LAST = 7'h4F;

    typedef enum logic [1:0] {
        BOOT8  = 2'd0,
        NIB_HI = 2'd1,
        NIB_LO = 2'd2
    } mode_e;

    // Address lies inside one of the two DDRAM line windows
    function automatic logic addr_legal(input logic [6:0] a);
        return (a <= LINE0_LAST) || ((a >= LINE1_BASE) && (a <= LINE1_LAST));
    endfunction

    // Address maps onto one of the 16 visible columns of either line
    function automatic logic cell_hit(input logic [6:0] a);
        return (a <= 7'h0F) || ((a >= LINE1_BASE) && (a <= FRAME_LAST));
    endfunction

    // Visible cell index: line bit then column
    function automatic logic [4:0] cell_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Auto-increment with the controller's line wrap behaviour
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (a == LINE0_LAST) return LINE1_BASE;
        if (a == LINE1_LAST) return LINE0_BASE;
        return a + 7'd1;
    endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Registers the raw LCD bus once and flags the falling edge of the enable strobe.
module lcd_strobe_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_dat,
    output logic       strobe,
    output logic [3:0] nib,
    output logic       rs,
    output logic       rw
);

    logic e_q;
    logic e_prev;

    // Single capture stage; e_prev clears on reset so no edge is seen until e is sampled high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q    <= 1'b0;
            e_prev <= 1'b0;
            rs     <= 1'b0;
            rw     <= 1'b0;
            nib    <= 4'h0;
        end else begin
            e_q    <= lcd_e;
            e_prev <= e_q;
            rs     <= lcd_rs;
            rw     <= lcd_rw;
            nib    <= lcd_dat;
        end
    end

    assign strobe = e_prev & ~e_q;

endmodule

// File: rtl/lcd_bus_decoder.sv
// Snoops an HD44780 bus and rebuilds the 2x16 character screen plus command activity.
module lcd_bus_decoder
    import lcd_pkg::*;
#(
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_e,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [3:0]   lcd_dat,
    output logic [255:0] strdata,
    output logic         cmd_valid,
    output logic [7:0]   cmd_byte,
    output logic         frame_done,
    output logic         four_bit,
    output logic         proto_err
);

    logic       strobe, s_rs, s_rw, stb;
    logic [3:0] s_nib;

    mode_e      state, state_nx;
    logic [3:0] hi_nib;
    logic       hi_rs;
    logic [6:0] addr;
    logic [0:31][7:0] cells;  // cell 0 sits in the MSB byte

    logic       commit, commit_rs, rs_err, latch_hi;
    logic [7:0] commit_byte;

    lcd_strobe_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_dat (lcd_dat),
        .strobe  (strobe),
        .nib     (s_nib),
        .rs      (s_rs),
        .rw      (s_rw)
    );

    // Read cycles never carry data for us
    assign stb     = strobe & ~s_rw;
    assign strdata = cells;

    // Mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT8;
        else     state <= state_nx;
    end

    // Mode transitions: function-set 4-bit leaves boot, nibble phases alternate
    always_comb begin
        state_nx = state;
        case (state)
            BOOT8:   if (commit && commit_byte == CMD_FUNC_4BIT) state_nx = NIB_HI;
            NIB_HI:  if (stb) state_nx = NIB_LO;
            NIB_LO:  if (stb) state_nx = NIB_HI;
            default: state_nx = BOOT8;
        endcase
    end

    // Byte assembly per mode; an rs change between nibbles drops the byte
    always_comb begin
        commit      = 1'b0;
        commit_rs   = 1'b0;
        commit_byte = 8'h00;
        rs_err      = 1'b0;
        latch_hi    = 1'b0;
        four_bit    = (state != BOOT8);
        case (state)
            BOOT8: begin
                if (stb && !s_rs) begin
                    commit      = 1'b1;
                    commit_byte = {s_nib, 4'h0};
                end
            end
            NIB_HI: latch_hi = stb;
            NIB_LO: begin
                if (stb) begin
                    if (s_rs == hi_rs) begin
                        commit      = 1'b1;
                        commit_rs   = hi_rs;
                        commit_byte = {hi_nib, s_nib};
                    end else begin
                        rs_err = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Command execution, screen writes and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            addr       <= LINE0_BASE;
            cells      <= {32{CLEAR_CHAR}};
            cmd_byte   <= 8'h00;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (latch_hi) begin
                hi_nib <= s_nib;
                hi_rs  <= s_rs;
            end
            if (rs_err) proto_err <= 1'b1;
            if (commit && !commit_rs) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= commit_byte;
                if (commit_byte == CMD_CLEAR) begin
                    cells <= {32{CLEAR_CHAR}};
                    addr  <= LINE0_BASE;
                end else if (commit_byte[7:1] == CMD_HOME[7:1]) begin
                    addr <= LINE0_BASE;
                end else if ((commit_byte & CMD_SET_DDRAM) != 8'h00) begin
                    addr <= commit_byte[6:0];
                    if (!addr_legal(commit_byte[6:0])) proto_err <= 1'b1;
                end
            end else if (commit && commit_rs) begin
                if (cell_hit(addr)) cells[cell_idx(addr)] <= commit_byte;
                if (addr == FRAME_LAST) frame_done <= 1'b1;
                addr <= next_addr(addr);
            end
        end
    end

endmodule

// File: doc/lcd_bus_decoder.md
LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

Interface
REQ-001 Parameter CLEAR_CHAR, default 8'h20, fill byte written to every character cell by reset and by the clear command.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 lcd_e  input  1  HD44780 enable strobe; data latched on its falling edge.
REQ-005 lcd_rs  input  1  register select: 0 = command, 1 = data.
REQ-006 lcd_rw  input  1  1 = read cycle; ignored by decoder.
REQ-007 lcd_dat  input  4  data nibble bus.
REQ-008 strdata  output  256  reconstructed 32-char screen; char 0 (line 0, col 0) in [255:248], char 31 (line 1, col 15) in [7:0].
REQ-009 cmd_valid  output  1  one-cycle pulse per decoded command byte.
REQ-010 cmd_byte  output  8  last decoded command byte, held until next command.
REQ-011 frame_done  output  1  one-cycle pulse when a data write lands at DDRAM address 7'h4F.
REQ-012 four_bit  output  1  1 once the bus has switched to 4-bit mode.
REQ-013 proto_err  output  1  sticky protocol-error flag.

Function
REQ-014 lcd_e, lcd_rs, lcd_rw, lcd_dat registered once; falling edge = registered e 0 while previous registered e 1; nibble and rs taken from the same register stage.
REQ-015 Strobes with registered rw = 1 discarded entirely, including nibble phase.
REQ-016 Modes: BOOT8 (reset state, four_bit = 0) and NIB_HI/NIB_LO (four_bit = 1).
REQ-017 BOOT8: each strobe is a full byte {lcd_dat, 4'h0}; rs = 1 strobes ignored; command 8'h20 moves to NIB_HI and sets four_bit; 8'h30 stays in BOOT8; all produce cmd_valid.
REQ-018 NIB_HI: strobe stores high nibble and rs, goes to NIB_LO; NIB_LO: strobe assembles {hi, lo}, commits byte, returns to NIB_HI.
REQ-019 rs differs between high and low nibble: byte discarded, proto_err set, return to NIB_HI.
REQ-020 Commit occurs on the clock edge after falling-edge detection (2 cycles after lcd_e first sampled low).
REQ-021 Command 8'h01: all 32 cells <= CLEAR_CHAR, address <= 7'h00.
REQ-022 Command 8'h02 or 8'h03: address <= 7'h00, cells unchanged.
REQ-023 Command with bit7 = 1: address <= byte[6:0].
REQ-024 Other commands: cmd_valid/cmd_byte only, no state change.
REQ-025 Data byte: address 7'h00-7'h0F writes cell addr; 7'h40-7'h4F writes cell 16+(addr-7'h40); other addresses discarded; address always increments.
REQ-026 Address wrap: 7'h27 -> 7'h40, 7'h67 -> 7'h00; set-address outside 7'h00-7'h27 / 7'h40-7'h67 sets proto_err, address still loaded.
REQ-027 frame_done pulses same cycle as the write to 7'h4F; cmd_valid and frame_done never high together.
REQ-028 proto_err cleared only by rst.

Reset
REQ-029 rst asserted at any time: mode BOOT8, four_bit 0, address 7'h00, all cells CLEAR_CHAR, cmd_byte 8'h00, cmd_valid 0, frame_done 0, proto_err 0, input registers 0; partial nibble dropped.
REQ-030 First strobe after reset release decoded in BOOT8 only if lcd_e was sampled high after release (no false edge from reset).

Structure
REQ-031 Shared package lcd_pkg: command codes (CLEAR, HOME, SET_DDRAM mask, FUNC_4BIT), line base addresses 7'h00/7'h40, wrap limits 7'h27/7'h67, mode enum.
REQ-032 One sub-module lcd_strobe_sync: input registration and falling-edge detection, outputs strobe, nib, rs, rw.

Verification
REQ-033 Boot: nibbles 3,3,3,2 with rs = 0 -> four cmd_valid pulses, cmd_byte 8'h20, four_bit = 1.
REQ-034 After boot: cmd 8'h80 then data "R00:" -> strdata[255:224] = "R00:", address 7'h04.
REQ-035 cmd 8'hC0 then 16 data bytes 8'h41 -> chars 16-31 = "A", frame_done one pulse on the 16th byte, address 7'h50.
REQ-036 Data at 7'h27 -> discarded, next address 7'h40; following data byte 8'h5A appears at char 16.
REQ-037 High nibble rs = 1, low nibble rs = 0 -> no cell change, proto_err = 1 until rst; next valid byte decodes normally.
REQ-038 rst mid-byte (after high nibble) -> all cells 8'h20, four_bit 0; boot sequence required again.
